// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, owner ids,
// default response timeout and the write-mask issue rule.
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam int unsigned TIMEOUT_CYC_DEF = 255;

    // Fetches and loads never write, so only an LSU store carries its mask.
    function automatic logic [7:0] issue_wmask(input logic owner, input logic we,
                                               input logic [7:0] wmask);
        return (owner == OWN_LSU && we) ? wmask : 8'h00;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: a lone requester wins, a tie goes to the
// requester that was not granted last. Purely combinational, one-hot grant.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == OWN_IFU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one memory port,
// one transaction at a time, with a response timeout in the WAIT state.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [63:0] ifu_rdata,
    output logic        ifu_resp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_we,
    input  logic [63:0] lsu_addr,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_rdata,
    output logic        lsu_resp_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_rdata
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [63:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [15:0] timer_q, timer_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [1:0]  gnt;
    logic        handshake;
    logic        resp_active;

    rr_arb2 u_arb (
        .req        ({lsu_req_valid, ifu_req_valid}),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    // Readies are gated by rst so nothing is accepted while reset is held.
    assign ifu_req_ready = rst && (state_q == ST_IDLE) && gnt[0];
    assign lsu_req_ready = rst && (state_q == ST_IDLE) && gnt[1];
    assign handshake     = (ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        timer_d      = timer_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    owner_d      = gnt[1] ? OWN_LSU : OWN_IFU;
                    last_grant_d = gnt[1] ? OWN_LSU : OWN_IFU;
                    addr_d       = gnt[1] ? lsu_addr : ifu_addr;
                    we_d         = gnt[1] && lsu_we;
                    wdata_d      = (gnt[1] && lsu_we) ? lsu_wdata : 64'd0;
                    wmask_d      = issue_wmask(gnt[1], lsu_we, lsu_wmask);
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    timer_d = 16'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response arriving on the expiry cycle still wins.
                if (mem_resp_valid) begin
                    rdata_d = we_q ? 64'd0 : mem_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    rdata_d = 64'd0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            addr_q       <= 64'd0;
            we_q         <= 1'b0;
            wdata_q      <= 64'd0;
            wmask_q      <= 8'h00;
            timer_q      <= 16'd0;
            rdata_q      <= 64'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            timer_q      <= timer_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign resp_active    = (state_q == ST_RESP);
    assign ifu_resp_valid = resp_active && (owner_q == OWN_IFU);
    assign lsu_resp_valid = resp_active && (owner_q == OWN_LSU);
    assign ifu_rdata      = ifu_resp_valid ? rdata_q : 64'd0;
    assign ifu_resp_err   = ifu_resp_valid && err_q;
    assign lsu_rdata      = lsu_resp_valid ? rdata_q : 64'd0;
    assign lsu_resp_err   = lsu_resp_valid && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short timeout: fetch/load/store flows,
// round-robin ties, timeout, reset mid-transaction and stray responses.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid, lsu_resp_err;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.TIMEOUT_CYC(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .ifu_resp_err   (ifu_resp_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_we         (lsu_we),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .lsu_resp_err   (lsu_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle with both requesters pending; releases after two edges.
    task automatic apply_reset();
        #1;
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        check("rst_ifu_rdy", ifu_req_ready, 1'b0);
        check("rst_lsu_rdy", lsu_req_ready, 1'b0);
        check("rst_mem_vld", mem_req_valid, 1'b0);
        check("rst_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        check("rst_mem_addr", mem_addr, 64'd0);
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    // Drives memory from the handshake cycle through the response cycle.
    task automatic run_txn(input logic lsu_own, input logic [63:0] rd);
        cyc();
        mem_req_ready = 1'b1;
        #1;
        check("stall_rdy", {ifu_req_ready, lsu_req_ready}, 2'b00);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = rd;
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        check("rr_resp_owner", {ifu_resp_valid, lsu_resp_valid}, lsu_own ? 2'b01 : 2'b10);
        check("rr_rdata", lsu_own ? lsu_rdata : ifu_rdata, rd);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        cyc();
        apply_reset();
        cyc();

        // IFU read at minimum latency
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0000;
        #1;
        check("ifu_rdy", {ifu_req_ready, lsu_req_ready}, 2'b10);
        cyc();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        check("ifu_mem_vld", mem_req_valid, 1'b1);
        check("ifu_mem_addr", mem_addr, 64'h8000_0000);
        check("ifu_mem_we", mem_we, 1'b0);
        check("ifu_mem_wmask", mem_wmask, 8'h00);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h13;
        #1;
        check("ifu_wait_vld", {mem_req_valid, ifu_resp_valid}, 2'b00);
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        check("ifu_resp_vld", {ifu_resp_valid, lsu_resp_valid}, 2'b10);
        check("ifu_rdata", ifu_rdata, 64'h13);
        check("ifu_err", ifu_resp_err, 1'b0);
        cyc();
        check("ifu_resp_once", ifu_resp_valid, 1'b0);

        // stray memory response while idle
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stray_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
            check("stray_rdata", ifu_rdata | lsu_rdata, 64'd0);
            cyc();
        end
        mem_resp_valid = 1'b0;

        // round-robin ties from reset: LSU, IFU, LSU
        apply_reset();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        lsu_we        = 1'b0;
        ifu_addr      = 64'h100;
        lsu_addr      = 64'h200;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rr_grant", {ifu_req_ready, lsu_req_ready}, (k == 1) ? 2'b10 : 2'b01);
            run_txn(k != 1, 64'h1000 + 64'(k));
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        cyc();

        // LSU write with memory ready delayed four cycles
        lsu_req_valid = 1'b1;
        lsu_we        = 1'b1;
        lsu_addr      = 64'h8000_1000;
        lsu_wdata     = 64'hDEAD_BEEF;
        lsu_wmask     = 8'h0F;
        #1;
        check("wr_rdy", {ifu_req_ready, lsu_req_ready}, 2'b01);
        cyc();
        lsu_req_valid = 1'b0;
        lsu_we        = 1'b0;
        lsu_addr      = '0;
        lsu_wdata     = '0;
        lsu_wmask     = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            mem_req_ready = (i == 4);
            #1;
            check("wr_vld", mem_req_valid, 1'b1);
            check("wr_addr", mem_addr, 64'h8000_1000);
            check("wr_wdata", mem_wdata, 64'hDEAD_BEEF);
            check("wr_wmask", mem_wmask, 8'h0F);
            check("wr_we", mem_we, 1'b1);
            cyc();
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hFFFF_FFFF;
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        check("wr_resp_vld", lsu_resp_valid, 1'b1);
        check("wr_rdata", lsu_rdata, 64'd0);
        check("wr_err", lsu_resp_err, 1'b0);
        cyc();

        // timeout, then response on the expiry cycle
        for (int rep = 0; rep < 2; rep++) begin
            lsu_req_valid = 1'b1;
            lsu_we        = 1'b0;
            lsu_addr      = 64'h300;
            #1;
            check("to_rdy", lsu_req_ready, 1'b1);
            cyc();
            lsu_req_valid = 1'b0;
            mem_req_ready = 1'b1;
            cyc();
            mem_req_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem_resp_valid = (rep == 1) && (i == 3);
                mem_rdata      = 64'h55;
                #1;
                check("to_wait", lsu_resp_valid, 1'b0);
                cyc();
            end
            mem_resp_valid = 1'b0;
            #1;
            check("to_resp_vld", lsu_resp_valid, 1'b1);
            check("to_err", lsu_resp_err, (rep == 0) ? 1'b1 : 1'b0);
            check("to_rdata", lsu_rdata, (rep == 0) ? 64'd0 : 64'h55);
            cyc();
        end

        // reset during WAIT drops the transaction
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h400;
        cyc();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        apply_reset();
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rstw_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
            check("rstw_memvld", mem_req_valid, 1'b0);
            cyc();
        end
        mem_resp_valid = 1'b0;
        ifu_req_valid  = 1'b1;
        #1;
        check("rstw_idle", ifu_req_ready, 1'b1);
        ifu_req_valid = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL set the maximum WAIT cycles before an error response (range 1..65535).
REQ-002 clk  in  1  sole clock; all state SHALL update on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ifu_req_valid in 1, ifu_req_ready out 1, ifu_addr in 64: instruction-fetch read request.
REQ-005 ifu_resp_valid out 1, ifu_rdata out 64, ifu_resp_err out 1: fetch response.
REQ-006 lsu_req_valid in 1, lsu_req_ready out 1, lsu_we in 1, lsu_addr in 64, lsu_wdata in 64, lsu_wmask in 8: load/store request.
REQ-007 lsu_resp_valid out 1, lsu_rdata out 64, lsu_resp_err out 1: load/store response.
REQ-008 mem_req_valid out 1, mem_req_ready in 1, mem_we out 1, mem_addr out 64, mem_wdata out 64, mem_wmask out 8: shared memory request port.
REQ-009 mem_resp_valid in 1, mem_rdata in 64: shared memory response port.

Function
REQ-010 Block SHALL hold at most one outstanding transaction; FSM states IDLE, REQ, WAIT, RESP.
REQ-011 IDLE: ready SHALL be 1 only for the arbitration winner, 0 for the loser; both 0 in all other states.
REQ-012 Arbitration: single valid requester wins; both valid -> round-robin, winner is the one not granted last; last_grant updates on handshake only.
REQ-013 Handshake (valid & ready) in IDLE SHALL latch owner, addr, we, wdata, wmask and move to REQ next cycle.
REQ-014 IFU transactions SHALL issue mem_we=0, mem_wmask=8'h00; LSU reads SHALL issue mem_wmask=8'h00; LSU writes SHALL pass lsu_wmask unchanged.
REQ-015 REQ: mem_req_valid=1 with latched fields held stable until mem_req_ready=1, then WAIT with timer cleared; no abort or timeout in REQ.
REQ-016 WAIT: mem_resp_valid=1 SHALL capture mem_rdata, err=0, go RESP; otherwise timer increments.
REQ-017 WAIT: timer reaching TIMEOUT_CYC without response SHALL go RESP with rdata=0, err=1; response and expiry in same cycle -> response wins, err=0.
REQ-018 RESP: owner's resp_valid SHALL be 1 for exactly one cycle with captured rdata/err; non-owner resp_valid=0; then IDLE.
REQ-019 Write responses SHALL return rdata=0; responses have no backpressure.
REQ-020 mem_resp_valid outside WAIT SHALL be ignored.
REQ-021 Minimum latency: handshake cycle t, mem_req_valid at t+1, response at t+3 when mem_req_ready at t+1 and mem_resp_valid at t+2.
REQ-022 Requests arriving in REQ/WAIT/RESP SHALL stall (ready=0) and not be dropped by the arbiter.
REQ-023 Timer width SHALL be 16 bits; no wrap before TIMEOUT_CYC.

Reset
REQ-024 rst=0 SHALL immediately force state IDLE, timer 0, last_grant=IFU, all latched fields 0.
REQ-025 While rst=0 all outputs SHALL be 0, including both readies.
REQ-026 Reset mid-transaction SHALL drop it silently; no response is produced after release.

Structure
REQ-027 Shared package SHALL hold the state encoding, owner constants (OWN_IFU=0, OWN_LSU=1) and TIMEOUT_CYC default.
REQ-028 Arbitration SHALL be a sub-module rr_arb2 (2 valids, last_grant in, one-hot grant out, combinational).
REQ-029 Estimated size 150-300 RTL lines.

Verification
REQ-030 IFU-only read addr 0x80000000, mem ready same cycle, rdata 0x00000013 next cycle -> ifu_resp_valid one cycle at t+3, ifu_rdata=0x13, err=0.
REQ-031 Both valid from reset for 3 transactions -> grants LSU, IFU, LSU.
REQ-032 LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 8'h0F, mem_req_ready delayed 4 cycles -> fields stable for 5 cycles, mem_wmask=8'h0F, lsu_rdata=0.
REQ-033 TIMEOUT_CYC=4, no mem_resp_valid -> lsu_resp_err=1, rdata=0, exactly 4 cycles after WAIT entry; repeat with response on expiry cycle -> err=0.
REQ-034 rst low during WAIT, then mem_resp_valid after release -> no resp_valid, state IDLE, both readies 0 during reset.
REQ-035 Stray mem_resp_valid in IDLE -> no response outputs change.
